// File: rtl/tdc_sel_pkg.sv
// Shared definitions for the delay-line tap select sequencer.
// Holds the scan FSM state encoding and the default tap-count and
// address-width values used by the sequencer, its interface and decoder.
package tdc_sel_pkg;

    localparam int NTAPS_DEF = 32;
    localparam int AW_DEF    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        SKIP  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tap_scan_seq_if.sv
// Control/status bundle for tap_scan_seq.
// master: the controller that requests scans and reads status.
// slave : the sequencer itself.
//   mode, addr, tap_en, first, last, dwell, loop, start, abort -> slave
//   sel_out, cur_addr, busy, tap_strobe, done, err             -> master
interface tap_scan_seq_if
    import tdc_sel_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = 16
);
    logic             mode;
    logic [AW-1:0]    addr;
    logic [NTAPS-1:0] tap_en;
    logic [AW-1:0]    first;
    logic [AW-1:0]    last;
    logic [DW-1:0]    dwell;
    logic             loop;
    logic             start;
    logic             abort;
    logic [NTAPS-1:0] sel_out;
    logic [AW-1:0]    cur_addr;
    logic             busy;
    logic             tap_strobe;
    logic             done;
    logic             err;

    modport master (
        output mode, addr, tap_en, first, last, dwell, loop, start, abort,
        input  sel_out, cur_addr, busy, tap_strobe, done, err
    );

    modport slave (
        input  mode, addr, tap_en, first, last, dwell, loop, start, abort,
        output sel_out, cur_addr, busy, tap_strobe, done, err
    );
endinterface

// File: rtl/tap_decoder.sv
// Combinational one-cold tap decoder.
//   addr   : tap address
//   tap_en : per-tap enable mask (0 = tap unusable)
//   sel    : active-low one-cold select; all ones when the tap is
//            disabled or the address is beyond the delay line
//   hit    : high when a tap is actually selected
module tap_decoder #(
    parameter int NTAPS = 32,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]    addr,
    input  logic [NTAPS-1:0] tap_en,
    output logic [NTAPS-1:0] sel,
    output logic             hit
);

    always_comb begin
        sel = '1;
        hit = 1'b0;
        for (int n = 0; n < NTAPS; n++) begin
            if (int'(addr) == n && tap_en[n]) begin
                sel[n] = 1'b0;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tap_scan_seq.sv
// Delay-line tap select sequencer.
// Manual mode drives the addressed tap directly; auto mode walks the
// taps first..last, holding each enabled tap for dwell+1 cycles and
// spending one all-ones cycle on each disabled tap.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : tap_scan_seq_if.slave (controls in, tap select/status out)
module tap_scan_seq
    import tdc_sel_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = 16
) (
    input logic           clk,
    input logic           rst,
    tap_scan_seq_if.slave bus
);

    localparam logic [NTAPS-1:0] ALL_OFF = '1;

    state_t           state;
    logic [AW-1:0]    first_r;
    logic [AW-1:0]    last_r;
    logic [DW-1:0]    dwell_r;
    logic             loop_r;
    logic [DW-1:0]    cnt;

    logic [AW-1:0]    dec_addr;
    logic [NTAPS-1:0] dec_sel;
    logic             dec_hit;
    logic [DW-1:0]    ent_dwell;
    state_t           ent_state;
    logic [NTAPS-1:0] ent_sel;
    logic             ent_strobe;

    // One decoder serves every path: the manual address in IDLE/manual,
    // the requested first tap on a start, first_r on a loop reload, and
    // the next tap while stepping through the range.
    always_comb begin
        dec_addr  = bus.cur_addr + AW'(1);
        ent_dwell = dwell_r;
        case (state)
            IDLE: begin
                dec_addr  = bus.mode ? bus.first : bus.addr;
                ent_dwell = bus.dwell;
            end
            DONE:    dec_addr = first_r;
            default: dec_addr = bus.cur_addr + AW'(1);
        endcase
    end

    tap_decoder #(.NTAPS(NTAPS), .AW(AW)) u_dec (
        .addr   (dec_addr),
        .tap_en (bus.tap_en),
        .sel    (dec_sel),
        .hit    (dec_hit)
    );

    // Outcome of entering the decoded tap: dwell on it if enabled,
    // otherwise spend a single all-ones skip cycle.
    always_comb begin
        ent_state  = dec_hit ? DWELL : SKIP;
        ent_sel    = dec_hit ? dec_sel : ALL_OFF;
        ent_strobe = dec_hit && (ent_dwell == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || (state != IDLE && bus.abort)) begin
            state          <= IDLE;
            bus.sel_out    <= ALL_OFF;
            bus.busy       <= 1'b0;
            bus.tap_strobe <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            cnt            <= '0;
            if (rst) begin
                bus.cur_addr <= '0;
            end
        end else begin
            bus.tap_strobe <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.mode) begin
                        bus.sel_out  <= dec_sel;
                        bus.cur_addr <= bus.addr;
                    end else if (bus.start && bus.first <= bus.last) begin
                        first_r        <= bus.first;
                        last_r         <= bus.last;
                        dwell_r        <= bus.dwell;
                        loop_r         <= bus.loop;
                        bus.cur_addr   <= bus.first;
                        bus.busy       <= 1'b1;
                        cnt            <= bus.dwell;
                        state          <= ent_state;
                        bus.sel_out    <= ent_sel;
                        bus.tap_strobe <= ent_strobe;
                    end else begin
                        bus.sel_out <= ALL_OFF;
                        bus.err     <= bus.start;
                    end
                end
                DWELL, SKIP: begin
                    if (state == DWELL && cnt != '0) begin
                        // Strobe is registered, so it is set one edge
                        // before the counter reaches zero.
                        cnt            <= cnt - DW'(1);
                        bus.tap_strobe <= (cnt == DW'(1));
                    end else if (bus.cur_addr == last_r) begin
                        state       <= DONE;
                        bus.sel_out <= ALL_OFF;
                        bus.done    <= 1'b1;
                    end else begin
                        bus.cur_addr   <= bus.cur_addr + AW'(1);
                        cnt            <= dwell_r;
                        state          <= ent_state;
                        bus.sel_out    <= ent_sel;
                        bus.tap_strobe <= ent_strobe;
                    end
                end
                DONE: begin
                    if (loop_r) begin
                        bus.cur_addr   <= first_r;
                        cnt            <= dwell_r;
                        state          <= ent_state;
                        bus.sel_out    <= ent_sel;
                        bus.tap_strobe <= ent_strobe;
                    end else begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        bus.sel_out <= ALL_OFF;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_scan_seq.sv
module tb_tap_scan_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tap_scan_seq_if #(.NTAPS(32), .AW(5), .DW(16)) bus ();

    tap_scan_seq #(.NTAPS(32), .AW(5), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.mode = 1'b0; bus.addr = 5'd3; bus.tap_en = '1;
        bus.first = '0; bus.last = '0; bus.dwell = '0; bus.loop = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        rst = 1'b1;
        tick(); tick();
        total++; if (bus.sel_out !== 32'hffffffff) begin bad++; $display("FAIL reset_sel got=%h want=ffffffff", bus.sel_out); end
        total++; if (bus.cur_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", bus.cur_addr); end
        total++; if ({bus.busy, bus.tap_strobe, bus.done, bus.err} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {bus.busy, bus.tap_strobe, bus.done, bus.err}); end
        rst = 1'b0;
    endtask

    task automatic test_manual();
        bus.mode = 1'b0; bus.addr = 5'd3; bus.tap_en = '1;
        tick();
        total++; if (bus.sel_out !== 32'hfffffff7) begin bad++; $display("FAIL man_sel3 got=%h want=fffffff7", bus.sel_out); end
        total++; if (bus.cur_addr !== 5'd3) begin bad++; $display("FAIL man_addr3 got=%0d want=3", bus.cur_addr); end
        bus.tap_en = 32'hfffffff7;
        tick();
        total++; if (bus.sel_out !== 32'hffffffff) begin bad++; $display("FAIL man_dis3 got=%h want=ffffffff", bus.sel_out); end
        bus.tap_en = '1; bus.addr = 5'd31;
        tick();
        total++; if (bus.sel_out !== 32'h7fffffff) begin bad++; $display("FAIL man_sel31 got=%h want=7fffffff", bus.sel_out); end
        bus.mode = 1'b1;
        tick();
        total++; if (bus.sel_out !== 32'hffffffff) begin bad++; $display("FAIL auto_idle got=%h want=ffffffff", bus.sel_out); end
    endtask

    task automatic test_scan();
        logic [31:0] exp_sel [8] = '{32'hfffffffb, 32'hfffffffb, 32'hfffffff7, 32'hfffffff7,
                                     32'hffffffef, 32'hffffffef, 32'hffffffff, 32'hffffffff};
        logic        exp_stb [8] = '{0, 1, 0, 1, 0, 1, 0, 0};
        logic        exp_don [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        logic        exp_bsy [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        int          strobes = 0;
        bus.mode = 1'b1; bus.tap_en = '1; bus.first = 5'd2; bus.last = 5'd4;
        bus.dwell = 16'd1; bus.loop = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.first = 5'd0; bus.last = 5'd31; bus.dwell = 16'd9;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            strobes += int'(bus.tap_strobe);
            total++; if (bus.sel_out !== exp_sel[k]) begin bad++; $display("FAIL scan_sel cyc=%0d got=%h want=%h", k + 1, bus.sel_out, exp_sel[k]); end
            total++; if (bus.tap_strobe !== exp_stb[k]) begin bad++; $display("FAIL scan_strobe cyc=%0d got=%b want=%b", k + 1, bus.tap_strobe, exp_stb[k]); end
            total++; if (bus.done !== exp_don[k]) begin bad++; $display("FAIL scan_done cyc=%0d got=%b want=%b", k + 1, bus.done, exp_don[k]); end
            total++; if (bus.busy !== exp_bsy[k]) begin bad++; $display("FAIL scan_busy cyc=%0d got=%b want=%b", k + 1, bus.busy, exp_bsy[k]); end
        end
        total++; if (strobes != 3) begin bad++; $display("FAIL scan_nstrobe got=%0d want=3", strobes); end
    endtask

    task automatic test_skip();
        logic [31:0] exp_sel [5] = '{32'hfffffffe, 32'hffffffff, 32'hfffffffb, 32'hffffffff, 32'hffffffff};
        logic        exp_stb [5] = '{1, 0, 1, 0, 0};
        logic        exp_don [5] = '{0, 0, 0, 1, 0};
        bus.tap_en = 32'hfffffffd; bus.first = 5'd0; bus.last = 5'd2;
        bus.dwell = 16'd0; bus.loop = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            total++; if (bus.sel_out !== exp_sel[k]) begin bad++; $display("FAIL skip_sel cyc=%0d got=%h want=%h", k + 1, bus.sel_out, exp_sel[k]); end
            total++; if (bus.tap_strobe !== exp_stb[k]) begin bad++; $display("FAIL skip_strobe cyc=%0d got=%b want=%b", k + 1, bus.tap_strobe, exp_stb[k]); end
            total++; if (bus.done !== exp_don[k]) begin bad++; $display("FAIL skip_done cyc=%0d got=%b want=%b", k + 1, bus.done, exp_don[k]); end
        end
        bus.tap_en = '1;
    endtask

    task automatic test_top_edge();
        bus.first = 5'd30; bus.last = 5'd31; bus.dwell = 16'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.sel_out !== 32'hbfffffff) begin bad++; $display("FAIL edge_sel30 got=%h want=bfffffff", bus.sel_out); end
        tick();
        total++; if (bus.sel_out !== 32'h7fffffff) begin bad++; $display("FAIL edge_sel31 got=%h want=7fffffff", bus.sel_out); end
        tick();
        total++; if (bus.done !== 1'b1 || bus.cur_addr !== 5'd31) begin bad++; $display("FAIL edge_done got=%b/%0d want=1/31", bus.done, bus.cur_addr); end
        tick();
        total++; if (bus.busy !== 1'b0 || bus.cur_addr !== 5'd31) begin bad++; $display("FAIL edge_idle got=%b/%0d want=0/31", bus.busy, bus.cur_addr); end
    endtask

    task automatic test_abort();
        bus.first = 5'd5; bus.last = 5'd8; bus.dwell = 16'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        total++; if (bus.sel_out !== 32'hffffffdf) begin bad++; $display("FAIL abort_pre got=%h want=ffffffdf", bus.sel_out); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++; if (bus.sel_out !== 32'hffffffff) begin bad++; $display("FAIL abort_sel got=%h want=ffffffff", bus.sel_out); end
        total++; if ({bus.busy, bus.done, bus.tap_strobe} !== 3'b000) begin bad++; $display("FAIL abort_flags got=%b want=000", {bus.busy, bus.done, bus.tap_strobe}); end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL abort_quiet cyc=%0d got=%b%b want=00", k, bus.done, bus.busy); end
        end
    endtask

    task automatic test_illegal_and_busy();
        int waited = 0;
        bus.first = 5'd9; bus.last = 5'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL illegal_err got=%b/%b want=1/0", bus.err, bus.busy); end
        tick();
        total++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL illegal_after got=%b/%b want=0/0", bus.err, bus.busy); end
        bus.first = 5'd0; bus.last = 5'd1; bus.dwell = 16'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1; bus.first = 5'd10; bus.last = 5'd10; bus.mode = 1'b0; bus.addr = 5'd20;
        tick();
        bus.start = 1'b0;
        total++; if (bus.sel_out !== 32'hfffffffe || bus.cur_addr !== 5'd0) begin bad++; $display("FAIL busy_start got=%h/%0d want=fffffffe/0", bus.sel_out, bus.cur_addr); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL busy_err got=%b want=0", bus.err); end
        while (bus.busy === 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        total++; if (waited != 7) begin bad++; $display("FAIL busy_len got=%0d want=7", waited); end
        tick();
        total++; if (bus.sel_out !== 32'hffefffff || bus.cur_addr !== 5'd20) begin bad++; $display("FAIL mode_idle got=%h/%0d want=ffefffff/20", bus.sel_out, bus.cur_addr); end
    endtask

    task automatic test_loop_reset();
        bus.mode = 1'b1; bus.first = 5'd7; bus.last = 5'd7; bus.dwell = 16'd1;
        bus.loop = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.loop = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) tick();
            total++; if (bus.done !== ((k % 3) == 0)) begin bad++; $display("FAIL loop_done cyc=%0d got=%b want=%b", k, bus.done, (k % 3) == 0); end
            total++; if (bus.tap_strobe !== ((k % 3) == 2)) begin bad++; $display("FAIL loop_strobe cyc=%0d got=%b want=%b", k, bus.tap_strobe, (k % 3) == 2); end
        end
        tick();
        total++; if (bus.sel_out !== 32'hffffff7f) begin bad++; $display("FAIL loop_tap got=%h want=ffffff7f", bus.sel_out); end
        rst = 1'b1; bus.start = 1'b1;
        tick();
        total++; if (bus.sel_out !== 32'hffffffff || bus.cur_addr !== 5'd0) begin bad++; $display("FAIL rst_sel got=%h/%0d want=ffffffff/0", bus.sel_out, bus.cur_addr); end
        total++; if ({bus.busy, bus.tap_strobe, bus.done, bus.err} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b want=0000", {bus.busy, bus.tap_strobe, bus.done, bus.err}); end
        rst = 1'b0; bus.start = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_stay got=%b want=0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_scan();
        test_skip();
        test_top_edge();
        test_abort();
        test_illegal_and_busy();
        test_loop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
